// File: rtl/alu_cmd_responder.sv
// alu_cmd_responder: handshaked 32-bit ALU command responder.
// A command is captured into a single stage register, evaluated, and then
// pushed into a small response FIFO that the consumer drains over valid/ready.
// Command credit counts the FIFO entries plus the in-flight stage entry, so a
// push out of the stage always finds space.
// Optional build macro ALU_CMD_FLAGS_EN adds per-entry {N,Z,C,V} flags on rsp_flags.
module alu_cmd_responder #(
    parameter int WIDTH      = 32,
    parameter int TAG_W      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [2:0]                    cmd_opcode,
    input  logic [WIDTH-1:0]              cmd_a,
    input  logic [WIDTH-1:0]              cmd_b,
    input  logic [TAG_W-1:0]              cmd_tag,
    input  logic                          cmd_enable,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [WIDTH-1:0]              rsp_result,
    output logic [TAG_W-1:0]              rsp_tag,
    output logic                          rsp_disabled,
`ifdef ALU_CMD_FLAGS_EN
    output logic [3:0]                    rsp_flags,
`endif
    output logic [$clog2(FIFO_DEPTH):0]   occupancy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_INC = 3'b010;
    localparam logic [2:0] OP_DEC = 3'b011;
    localparam logic [2:0] OP_PSA = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_OR  = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    // ALU result; disabled commands always produce zero.
    function automatic logic [WIDTH-1:0] alu_result(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             en
    );
        logic [WIDTH-1:0] one;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        if (!en) begin
            alu_result = '0;
        end else begin
            case (op)
                OP_ADD:  alu_result = a + b;
                OP_SUB:  alu_result = a - b;
                OP_INC:  alu_result = a + one;
                OP_DEC:  alu_result = a - one;
                OP_PSA:  alu_result = a;
                OP_NOT:  alu_result = ~a;
                OP_OR:   alu_result = a | b;
                OP_AND:  alu_result = a & b;
                default: alu_result = '0;
            endcase
        end
    endfunction

`ifdef ALU_CMD_FLAGS_EN
    // {N,Z,C,V}; inc/dec reuse the add/sub rules with a unit second operand.
    function automatic logic [3:0] alu_flags(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             en
    );
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        y = ((op == OP_INC) || (op == OP_DEC)) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
        r = alu_result(op, a, b, en);
        if (!en) begin
            alu_flags = 4'b0100;
        end else begin
            case (op)
                OP_ADD, OP_INC: begin
                    c = (r < a);
                    v = (a[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
                end
                OP_SUB, OP_DEC: begin
                    c = (a < y);
                    v = (a[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != a[WIDTH-1]);
                end
                default: begin
                    c = 1'b0;
                    v = 1'b0;
                end
            endcase
            alu_flags = {r[WIDTH-1], (r == '0), c, v};
        end
    endfunction
`endif

    logic                 rst_q;
    logic                 s_valid_q, s_valid_d;
    logic [2:0]           s_op_q, s_op_d;
    logic [WIDTH-1:0]     s_a_q, s_a_d;
    logic [WIDTH-1:0]     s_b_q, s_b_d;
    logic [TAG_W-1:0]     s_tag_q, s_tag_d;
    logic                 s_en_q, s_en_d;

    logic [WIDTH-1:0]     res_mem_q [FIFO_DEPTH];
    logic [WIDTH-1:0]     res_mem_d [FIFO_DEPTH];
    logic [TAG_W-1:0]     tag_mem_q [FIFO_DEPTH];
    logic [TAG_W-1:0]     tag_mem_d [FIFO_DEPTH];
    logic                 dis_mem_q [FIFO_DEPTH];
    logic                 dis_mem_d [FIFO_DEPTH];
`ifdef ALU_CMD_FLAGS_EN
    logic [3:0]           flg_mem_q [FIFO_DEPTH];
    logic [3:0]           flg_mem_d [FIFO_DEPTH];
`endif

    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW-1:0]        occupancy_q, occupancy_d;

    logic                 accept_s;
    logic                 push_s;
    logic                 pop_s;

    // Credit uses only registered state; a same-cycle pop never raises ready.
    assign cmd_ready = !rst_q && ((count_q + CW'(s_valid_q)) < CW'(FIFO_DEPTH));
    assign accept_s  = cmd_valid && cmd_ready;
    assign push_s    = s_valid_q;
    assign pop_s     = rsp_valid && rsp_ready;
    assign occupancy = occupancy_q;

    // Stage register: capture an accepted command, otherwise empty the stage.
    always_comb begin
        s_valid_d = accept_s;
        s_op_d    = s_op_q;
        s_a_d     = s_a_q;
        s_b_d     = s_b_q;
        s_tag_d   = s_tag_q;
        s_en_d    = s_en_q;
        if (accept_s) begin
            s_op_d  = cmd_opcode;
            s_a_d   = cmd_a;
            s_b_d   = cmd_b;
            s_tag_d = cmd_tag;
            s_en_d  = cmd_enable;
        end else begin
            s_op_d  = s_op_q;
        end
    end

    // Response FIFO next state: stage push, consumer pop, count and occupancy.
    always_comb begin
        res_mem_d = res_mem_q;
        tag_mem_d = tag_mem_q;
        dis_mem_d = dis_mem_q;
`ifdef ALU_CMD_FLAGS_EN
        flg_mem_d = flg_mem_q;
`endif
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        if (push_s) begin
            res_mem_d[wr_ptr_q] = alu_result(s_op_q, s_a_q, s_b_q, s_en_q);
            tag_mem_d[wr_ptr_q] = s_tag_q;
            dis_mem_d[wr_ptr_q] = !s_en_q;
`ifdef ALU_CMD_FLAGS_EN
            flg_mem_d[wr_ptr_q] = alu_flags(s_op_q, s_a_q, s_b_q, s_en_q);
`endif
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        occupancy_d = count_d + CW'(s_valid_d);
    end

    // Response outputs present the FIFO head, zero when the FIFO is empty.
    always_comb begin
        rsp_valid = (count_q != '0);
        if (rsp_valid) begin
            rsp_result   = res_mem_q[rd_ptr_q];
            rsp_tag      = tag_mem_q[rd_ptr_q];
            rsp_disabled = dis_mem_q[rd_ptr_q];
`ifdef ALU_CMD_FLAGS_EN
            rsp_flags    = flg_mem_q[rd_ptr_q];
`endif
        end else begin
            rsp_result   = '0;
            rsp_tag      = '0;
            rsp_disabled = 1'b0;
`ifdef ALU_CMD_FLAGS_EN
            rsp_flags    = 4'b0000;
`endif
        end
    end

    // State registers; reset discards the stage and every queued response.
    always_ff @(posedge clk) begin
        if (rst) begin
            rst_q       <= 1'b1;
            s_valid_q   <= 1'b0;
            s_op_q      <= 3'b000;
            s_a_q       <= '0;
            s_b_q       <= '0;
            s_tag_q     <= '0;
            s_en_q      <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            occupancy_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                res_mem_q[i] <= '0;
                tag_mem_q[i] <= '0;
                dis_mem_q[i] <= 1'b0;
`ifdef ALU_CMD_FLAGS_EN
                flg_mem_q[i] <= 4'b0000;
`endif
            end
        end else begin
            rst_q       <= 1'b0;
            s_valid_q   <= s_valid_d;
            s_op_q      <= s_op_d;
            s_a_q       <= s_a_d;
            s_b_q       <= s_b_d;
            s_tag_q     <= s_tag_d;
            s_en_q      <= s_en_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            occupancy_q <= occupancy_d;
            res_mem_q   <= res_mem_d;
            tag_mem_q   <= tag_mem_d;
            dis_mem_q   <= dis_mem_d;
`ifdef ALU_CMD_FLAGS_EN
            flg_mem_q   <= flg_mem_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_cmd_responder.sv
// Self-checking bench for alu_cmd_responder with a response scoreboard.
module tb_alu_cmd_responder;

    typedef struct packed {
        logic [31:0] res;
        logic [3:0]  tag;
        logic        dis;
        logic [3:0]  flg;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [3:0]  cmd_tag;
    logic        cmd_enable;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic        rsp_disabled;
`ifdef ALU_CMD_FLAGS_EN
    logic [3:0]  rsp_flags;
`endif
    logic [2:0]  occupancy;

    int   checks;
    int   errors;
    int   cyc;
    logic will_accept;
    exp_t exp_q[$];
    exp_t got_q[$];

    alu_cmd_responder #(.WIDTH(32), .TAG_W(4), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_opcode   (cmd_opcode),
        .cmd_a        (cmd_a),
        .cmd_b        (cmd_b),
        .cmd_tag      (cmd_tag),
        .cmd_enable   (cmd_enable),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_result   (rsp_result),
        .rsp_tag      (rsp_tag),
        .rsp_disabled (rsp_disabled),
`ifdef ALU_CMD_FLAGS_EN
        .rsp_flags    (rsp_flags),
`endif
        .occupancy    (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model of one response.
    function automatic exp_t model(input logic [2:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [3:0] tag,
                                   input logic en);
        exp_t        e;
        logic [32:0] w;
        logic        c;
        logic        v;
        e.tag = tag;
        e.dis = !en;
        c = 1'b0;
        v = 1'b0;
        w = 33'd0;
        if (!en) begin
            e.res = 32'h0;
        end else begin
            case (op)
                3'd0: begin w = {1'b0, a} + {1'b0, b}; c = w[32];
                            v = (a[31] == b[31]) && (w[31] != a[31]); end
                3'd1: begin w = {1'b0, a} - {1'b0, b}; c = (a < b);
                            v = (a[31] != b[31]) && (w[31] != a[31]); end
                3'd2: begin w = {1'b0, a} + 33'd1; c = (a == 32'hFFFF_FFFF);
                            v = (a == 32'h7FFF_FFFF); end
                3'd3: begin w = {1'b0, a} - 33'd1; c = (a == 32'h0);
                            v = (a == 32'h8000_0000); end
                3'd4: w = {1'b0, a};
                3'd5: w = {1'b0, ~a};
                3'd6: w = {1'b0, a | b};
                default: w = {1'b0, a & b};
            endcase
            e.res = w[31:0];
        end
`ifdef ALU_CMD_FLAGS_EN
        e.flg = en ? {e.res[31], (e.res == 32'h0), c, v} : 4'b0100;
`else
        e.flg = 4'b0000;
`endif
        return e;
    endfunction

    // Scoreboard: push on accept, pop and compare on response handshake.
    always @(negedge clk) begin
        exp_t e;
        exp_t g;
        if (!rst) begin
            will_accept = cmd_valid && cmd_ready;
            if (cmd_valid && cmd_ready)
                exp_q.push_back(model(cmd_opcode, cmd_a, cmd_b, cmd_tag, cmd_enable));
            if (rsp_valid && rsp_ready) begin
                g.res = rsp_result;
                g.tag = rsp_tag;
                g.dis = rsp_disabled;
`ifdef ALU_CMD_FLAGS_EN
                g.flg = rsp_flags;
`else
                g.flg = 4'b0000;
`endif
                got_q.push_back(g);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: got res=%h tag=%h, required no response", g.res, g.tag);
                end else begin
                    e = exp_q.pop_front();
                    if (g !== e) begin
                        errors++;
                        $display("FAIL rsp_compare: got res=%h tag=%h dis=%b flg=%b, required res=%h tag=%h dis=%b flg=%b",
                                 g.res, g.tag, g.dis, g.flg, e.res, e.tag, e.dis, e.flg);
                    end
                end
            end
        end else begin
            will_accept = 1'b0;
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until it is accepted (bounded).
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] tag, input logic en);
        logic acc;
        acc        = 1'b0;
        cmd_valid  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_tag    = tag;
        cmd_enable = en;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            acc = will_accept;
            #1;
            if (acc) break;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: tag=%h not accepted, required accept within 20 cycles", tag);
        end
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
    endtask

    // Wait for scoreboard and DUT to drain (bounded).
    task automatic wait_empty();
        logic done;
        done = 1'b0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && rsp_valid === 1'b0 && occupancy === 3'd0) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d occupancy=%0d, required 0 and 0", exp_q.size(), occupancy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
        exp_q.delete(); got_q.delete();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready: got %b required 0", cmd_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid); end
        checks++; if (rsp_result !== 32'h0) begin errors++; $display("FAIL rst_rsp_result: got %h required 0", rsp_result); end
        checks++; if (rsp_tag !== 4'h0 || rsp_disabled !== 1'b0) begin errors++; $display("FAIL rst_rsp_tag_dis: got %h/%b required 0/0", rsp_tag, rsp_disabled); end
        checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL rst_occupancy: got %0d required 0", occupancy); end
`ifdef ALU_CMD_FLAGS_EN
        checks++; if (rsp_flags !== 4'b0000) begin errors++; $display("FAIL rst_flags: got %b required 0000", rsp_flags); end
`endif
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_release_ready0: got %b required 0", cmd_ready); end
        @(negedge clk);
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready1: got %b required 1", cmd_ready); end
    endtask

    task automatic test_single();
        sync();
        send(3'd0, 32'd5, 32'd3, 4'd1, 1'b1);
        idle();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || occupancy !== 3'd1) begin errors++; $display("FAIL single_stage: got valid=%b occ=%0d required 0/1", rsp_valid, occupancy); end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h8 || rsp_tag !== 4'd1 || rsp_disabled !== 1'b0) begin
            errors++;
            $display("FAIL single_rsp: got v=%b res=%h tag=%h dis=%b required 1/00000008/1/0", rsp_valid, rsp_result, rsp_tag, rsp_disabled);
        end
        wait_empty();
    endtask

    task automatic test_back_to_back();
        logic [31:0] want [7];
        int          c0;
        want = '{32'h2, 32'h6, 32'h4, 32'h5, 32'hFFFF_FFFA, 32'h7, 32'h1};
        sync();
        got_q.delete();
        c0 = cyc;
        for (int i = 1; i <= 7; i++) send(3'(i), 32'd5, 32'd3, 4'(i + 1), 1'b1);
        checks++; if (cyc - c0 != 7) begin errors++; $display("FAIL b2b_throughput: got %0d cycles required 7", cyc - c0); end
        idle();
        wait_empty();
        checks++; if (got_q.size() != 7) begin errors++; $display("FAIL b2b_count: got %0d required 7", got_q.size()); end
        for (int i = 0; i < 7 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].res !== want[i] || got_q[i].tag !== 4'(i + 2)) begin
                errors++;
                $display("FAIL b2b_result%0d: got %h tag %h required %h tag %h", i, got_q[i].res, got_q[i].tag, want[i], 4'(i + 2));
            end
        end
    endtask

    task automatic test_disabled();
        sync();
        send(3'd0, 32'd5, 32'd3, 4'd9, 1'b0);
        idle();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== 32'h0 || rsp_disabled !== 1'b1) begin
            errors++;
            $display("FAIL disabled_rsp: got v=%b res=%h dis=%b required 1/00000000/1", rsp_valid, rsp_result, rsp_disabled);
        end
`ifdef ALU_CMD_FLAGS_EN
        checks++; if (rsp_flags !== 4'b0100) begin errors++; $display("FAIL disabled_flags: got %b required 0100", rsp_flags); end
`endif
        wait_empty();
    endtask

    task automatic test_wrap();
        sync();
        got_q.delete();
        send(3'd2, 32'hFFFF_FFFF, 32'd0, 4'hA, 1'b1);
        send(3'd3, 32'h0, 32'd0, 4'hB, 1'b1);
        idle();
        wait_empty();
        checks++;
        if (got_q.size() != 2 || got_q[0].res !== 32'h0 || got_q[1].res !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_results: got n=%0d required 00000000 then FFFFFFFF", got_q.size());
        end
`ifdef ALU_CMD_FLAGS_EN
        checks++;
        if (got_q.size() != 2 || got_q[0].flg !== 4'b0110 || got_q[1].flg !== 4'b1010) begin
            errors++;
            $display("FAIL wrap_flags: got n=%0d required 0110 then 1010", got_q.size());
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [31:0] head_res;
        logic [3:0]  head_tag;
        sync();
        got_q.delete();
        rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(3'(i + 3), 32'(i * 17), 32'h0F0F_0F0F, 4'(i), 1'b1);
        cmd_valid = 1'b1; cmd_opcode = 3'd0; cmd_a = 32'd50; cmd_b = 32'd60; cmd_tag = 4'd5; cmd_enable = 1'b1;
        @(negedge clk);
        head_res = rsp_result;
        head_tag = rsp_tag;
        for (int n = 0; n < 4; n++) begin
            checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_low%0d: got %b required 0", n, cmd_ready); end
            @(negedge clk);
        end
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_occupancy: got %0d required 4", occupancy); end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_result !== head_res || rsp_tag !== head_tag || head_tag !== 4'd1) begin
            errors++;
            $display("FAIL bp_head_stable: got res=%h tag=%h required res=%h tag=1", rsp_result, rsp_tag, head_res);
        end
        sync();
        rsp_ready = 1'b1;
        send(3'd0, 32'd50, 32'd60, 4'd5, 1'b1);
        send(3'd1, 32'd70, 32'd80, 4'd6, 1'b1);
        idle();
        wait_empty();
        checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %b required 1", cmd_ready); end
        checks++; if (got_q.size() != 6) begin errors++; $display("FAIL bp_count: got %0d required 6", got_q.size()); end
        for (int i = 0; i < 6 && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i].tag !== 4'(i + 1)) begin errors++; $display("FAIL bp_order%0d: got tag %h required %h", i, got_q[i].tag, 4'(i + 1)); end
        end
    endtask

    task automatic test_reset_mid();
        sync();
        rsp_ready = 1'b0;
        for (int i = 1; i <= 4; i++) send(3'd0, 32'(i), 32'd1, 4'(i + 10), 1'b1);
        idle();
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL rmid_pre_occ: got %0d required 4", occupancy); end
        @(posedge clk); #1; rst = 1'b0; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL rmid_cleared: got valid=%b occ=%0d required 0/0", rsp_valid, occupancy);
        end
        sync();
        got_q.delete();
        send(3'd0, 32'd100, 32'd23, 4'd7, 1'b1);
        idle();
        wait_empty();
        checks++;
        if (got_q.size() != 1 || got_q[0].res !== 32'd123 || got_q[0].tag !== 4'd7) begin
            errors++;
            $display("FAIL rmid_post: got n=%0d required exactly one response 0000007b tag 7", got_q.size());
        end
    endtask

    initial begin
        checks = 0; errors = 0; cyc = 0; will_accept = 1'b0;
        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = 3'd0; cmd_a = 32'd0; cmd_b = 32'd0;
        cmd_tag = 4'd0; cmd_enable = 1'b0; rsp_ready = 1'b1;
        test_reset();
        test_single();
        test_back_to_back();
        test_disabled();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
